sigmoid_pwl: RTL and testbench

// - Fixed-point logistic sigmoid y = 1/(1+e^-x) using the PLAN piecewise-linear

---
 rtl/sigmoid_pwl_if.sv | 29 ++
 rtl/sigmoid_pwl.sv | 144 ++++++++++++++
 tb/tb_sigmoid_pwl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/sigmoid_pwl_if.sv
// Sample/result bus for the piecewise-linear sigmoid stage.
// Handshake: valid-only with no backpressure. A sender asserts in_valid for
// exactly the cycles in which 'in' holds a sample. The stage asserts out_valid
// for one cycle per accepted sample, in input order. 'out' holds its value
// while out_valid is low.
interface sigmoid_pwl_if #(
    parameter int DW = 16
);
    logic          in_valid;
    logic [DW-1:0] in;
    logic          out_valid;
    logic [DW-1:0] out;

    // Producer of samples and consumer of results.
    modport master (
        output in_valid,
        output in,
        input  out_valid,
        input  out
    );

    // The sigmoid stage itself.
    modport slave (
        input  in_valid,
        input  in,
        output out_valid,
        output out
    );
endinterface

// File: rtl/sigmoid_pwl.sv
// Fixed-point logistic sigmoid using the PLAN piecewise-linear approximation.
// The input is a signed Q4.12 sample, and the result is Q4.12 in 0..4096.
// The datapath uses only shifts and adds.
// Optional macro SIGMOID_PIPE_EN inserts a register between abs/region select
// and the add/sign stage. Latency goes from 1 to 2 cycles, and the numerical
// results do not change.
module sigmoid_pwl #(
    parameter int DW   = 16,
    parameter int FRAC = 12
) (
    input  logic           clk,
    input  logic           rst,
    sigmoid_pwl_if.slave   bus
);
    localparam int W = DW + 1;
    typedef logic [W-1:0] ext_t;

    // Region encoding on a = |x|; a boundary value belongs to the upper region.
    typedef enum logic [1:0] {
        R_LO  = 2'd0,   // a < 1.0         slope 1/4
        R_ONE = 2'd1,   // 1.0 <= a < 2.375 slope 1/8
        R_MID = 2'd2,   // 2.375 <= a < 5.0 slope 1/32
        R_SAT = 2'd3    // a >= 5.0         flat at 1.0
    } region_t;

    localparam ext_t ONE    = ext_t'(1 << FRAC);
    localparam ext_t T_ONE  = ext_t'(1 << FRAC);              // 1.0
    localparam ext_t T_MID  = ext_t'(19 << (FRAC - 3));       // 2.375
    localparam ext_t T_SAT  = ext_t'(5 << FRAC);              // 5.0
    localparam ext_t OFF_LO = ext_t'(1 << (FRAC - 1));        // 0.5
    localparam ext_t OFF_ON = ext_t'(5 << (FRAC - 3));        // 0.625
    localparam ext_t OFF_MI = ext_t'(27 << (FRAC - 5));       // 0.84375
    localparam ext_t A_MAX  = ext_t'((1 << (DW - 1)) - 1);

    // Front end: sign extension, magnitude, saturation and region select.
    logic signed [W-1:0] x_ext;
    ext_t                a_raw;
    ext_t                a_sat;
    region_t             region;
    logic                neg;

    assign x_ext = {bus.in[DW-1], bus.in};
    assign neg   = bus.in[DW-1];
    // -(-32768) = 32768 fits in DW+1 bits and is then saturated to 32767.
    assign a_raw = neg ? ext_t'(-x_ext) : ext_t'(x_ext);
    assign a_sat = (a_raw > A_MAX) ? A_MAX : a_raw;

    // Pick the segment; the comparisons use >= so boundaries go to the upper segment.
    always_comb begin
        region = R_LO;
        if (a_sat >= T_SAT) begin
            region = R_SAT;
        end else if (a_sat >= T_MID) begin
            region = R_MID;
        end else if (a_sat >= T_ONE) begin
            region = R_ONE;
        end
    end

    // Operands that feed the add/sign stage (registered or direct).
    logic    c_valid;
    ext_t    c_a;
    region_t c_region;
    logic    c_neg;

`ifdef SIGMOID_PIPE_EN
    logic    s1_valid;
    ext_t    s1_a;
    region_t s1_region;
    logic    s1_neg;

    // Mid-pipe register: holds magnitude, region and sign for the second stage.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_region <= R_LO;
            s1_neg    <= 1'b0;
        end else begin
            s1_valid  <= bus.in_valid;
            s1_a      <= a_sat;
            s1_region <= region;
            s1_neg    <= neg;
        end
    end

    assign c_valid  = s1_valid;
    assign c_a      = s1_a;
    assign c_region = s1_region;
    assign c_neg    = s1_neg;
`else
    assign c_valid  = bus.in_valid;
    assign c_a      = a_sat;
    assign c_region = region;
    assign c_neg    = neg;
`endif

    // Back end: segment value p, sign reflection about 0.5, and the range clamp.
    ext_t                p;
    logic signed [W-1:0] y_s;
    ext_t                y;

    always_comb begin
        p   = ONE;
        y_s = '0;
        y   = '0;
        unique case (c_region)
            R_SAT: p = ONE;
            R_MID: p = (c_a >> 5) + OFF_MI;
            R_ONE: p = (c_a >> 3) + OFF_ON;
            R_LO:  p = (c_a >> 2) + OFF_LO;
            default: p = ONE;
        endcase
        // A negative x gives sigmoid(-a) = 1 - sigmoid(a).
        y_s = c_neg ? ($signed(ONE) - $signed(p)) : $signed(p);
        // This clamp only guards the result range; valid inputs never reach it.
        if (y_s < 0) begin
            y = '0;
        end else if (y_s > $signed(ONE)) begin
            y = ONE;
        end else begin
            y = ext_t'(y_s);
        end
    end

    logic          out_valid_q;
    logic [DW-1:0] out_q;

    // Output register: a one-cycle valid pulse per sample; the data holds between samples.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            out_valid_q <= c_valid;
            if (c_valid) begin
                out_q <= y[DW-1:0];
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;
endmodule

// File: tb/tb_sigmoid_pwl.sv
// Bench for sigmoid_pwl. It uses directed vectors with hand-computed expected
// values. A scoreboard queue is filled by the driver and drained by an
// independent monitor.
module tb_sigmoid_pwl;
`ifdef SIGMOID_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk;
    logic rst;
    int   cyc;
    logic rst_q;
    bit   mon_en;

    int checks;
    int errors;

    logic [15:0] exp_q[$];
    int          issue_q[$];
    logic [15:0] last_exp;

    sigmoid_pwl_if #(.DW(16)) bus ();

    sigmoid_pwl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock and cycle counter; rst_q records what the DUT saw at each edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    // Driver: present one sample for one cycle; optionally expect a result.
    task automatic send(input logic [15:0] x, input logic [15:0] e, input bit push);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in       = x;
        if (push) begin
            exp_q.push_back(e);
            issue_q.push_back(cyc);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in       = 16'h0;
        end
    endtask

    // Monitor: compare every presented result; otherwise check reset value or hold.
    always @(negedge clk) begin
        if (mon_en) begin
            if (!rst_q) begin
                checks++;
                if (bus.out_valid !== 1'b0 || bus.out !== 16'd0) begin
                    errors++;
                    $display("FAIL reset_state: out_valid=%b out=%0d, required out_valid=0 out=0",
                             bus.out_valid, bus.out);
                end
                last_exp = 16'd0;
            end else if (bus.out_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out: out_valid=1 out=%0d at cycle %0d, required no output",
                             $signed(bus.out), cyc);
                end else begin
                    logic [15:0] e;
                    int          t;
                    e = exp_q.pop_front();
                    t = issue_q.pop_front();
                    if (bus.out !== e) begin
                        errors++;
                        $display("FAIL result: out=%0d, required %0d", $signed(bus.out), $signed(e));
                    end
                    checks++;
                    if (cyc - t != LAT) begin
                        errors++;
                        $display("FAIL latency: %0d cycles, required %0d", cyc - t, LAT);
                    end
                    last_exp = e;
                end
            end else if (bus.out_valid === 1'b0) begin
                checks++;
                if (bus.out !== last_exp) begin
                    errors++;
                    $display("FAIL hold: out=%0d, required %0d", $signed(bus.out), $signed(last_exp));
                end
            end else begin
                checks++;
                errors++;
                $display("FAIL out_valid_x: out_valid=%b, required 0 or 1", bus.out_valid);
            end
        end
    end

    // Directed vectors: input and hand-computed expected output.
    logic [15:0] vec_in  [12];
    logic [15:0] vec_exp [12];
    logic [15:0] st_in   [5];
    logic [15:0] st_exp  [5];

    initial begin
        vec_in[0]  = 16'sd0;      vec_exp[0]  = 16'd2048;
        vec_in[1]  = 16'sd2048;   vec_exp[1]  = 16'd2560;
        vec_in[2]  = -16'sd2048;  vec_exp[2]  = 16'd1536;
        vec_in[3]  = 16'sd4096;   vec_exp[3]  = 16'd3072;
        vec_in[4]  = -16'sd4096;  vec_exp[4]  = 16'd1024;
        vec_in[5]  = 16'sd8192;   vec_exp[5]  = 16'd3584;
        vec_in[6]  = 16'sd9728;   vec_exp[6]  = 16'd3760;
        vec_in[7]  = 16'sd20480;  vec_exp[7]  = 16'd4096;
        vec_in[8]  = 16'sd32767;  vec_exp[8]  = 16'd4096;
        vec_in[9]  = 16'h8000;    vec_exp[9]  = 16'd0;
        vec_in[10] = -16'sd20480; vec_exp[10] = 16'd0;
        vec_in[11] = 16'sd4095;   vec_exp[11] = 16'd3071;   // just below 1.0: 1023+2048

        st_in[0] = 16'sd0;     st_exp[0] = 16'd2048;
        st_in[1] = 16'sd4096;  st_exp[1] = 16'd3072;
        st_in[2] = -16'sd4096; st_exp[2] = 16'd1024;
        st_in[3] = 16'sd8192;  st_exp[3] = 16'd3584;
        st_in[4] = 16'sd20480; st_exp[4] = 16'd4096;
    end

    // Stimulus sequence.
    initial begin
        checks       = 0;
        errors       = 0;
        cyc          = 0;
        rst_q        = 1'b0;
        mon_en       = 1'b0;
        last_exp     = 16'd0;
        rst          = 1'b0;
        bus.in_valid = 1'b1;
        bus.in       = 16'sd4096;

        // Reset held for two cycles while a valid sample is presented.
        @(posedge clk);
        mon_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in       = 16'h0;
        idle(2);

        // Isolated directed vectors.
        for (int i = 0; i < 12; i++) begin
            send(vec_in[i], vec_exp[i], 1'b1);
            idle(LAT + 1);
        end

        // Back-to-back stream.
        for (int i = 0; i < 5; i++) begin
            send(st_in[i], st_exp[i], 1'b1);
        end
        idle(LAT + 2);

        // Gap pattern 1,0,1; the hold check covers the idle cycle.
        send(16'sd2048, 16'd2560, 1'b1);
        idle(1);
        send(-16'sd2048, 16'd1536, 1'b1);
        idle(LAT + 2);

        // Reset arrives together with a sample: that sample must never emerge.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in       = 16'sd8192;
        rst          = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        idle(LAT + 2);

`ifdef SIGMOID_PIPE_EN
        // Sample already in the mid-pipe register when reset asserts.
        send(16'sd4096, 16'd0, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst          = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        idle(LAT + 2);
`endif

        // Recovery after reset.
        send(-16'sd4096, 16'd1024, 1'b1);
        idle(LAT + 3);

        // Every expected result must have been seen within the budget.
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
